nixie_frame_decoder: RTL and testbench

NIXIE_FRAME_DECODER -- requirements
Module: nixie_frame_decoder

---
 rtl/nixie_pkg.sv | 30 +++
 rtl/nixie_digit_decode.sv | 31 +++
 rtl/nixie_frame_decoder.sv | 176 +++++++++++++++++
 tb/tb_nixie_frame_decoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nixie_pkg.sv
// Shared constants, FSM encoding and decoded-frame payload for the nixie
// frame decoder.
//   No ports. Imported by nixie_digit_decode and nixie_frame_decoder.
package nixie_pkg;

    localparam int unsigned NIXIE_FRAME_BITS = 96;
    localparam int unsigned NIXIE_TUBES      = 8;
    localparam int unsigned NIXIE_FIELD_BITS = 12;
    localparam int unsigned NIXIE_DIGIT_BITS = 10;
    localparam int unsigned NIXIE_CNT_W      = 7;   // holds 0..97 (saturation value)
    localparam int unsigned NIXIE_BCD_W      = 4 * NIXIE_TUBES;
    localparam int unsigned NIXIE_DP_W       = 2 * NIXIE_TUBES;

    localparam logic [3:0] NIXIE_BLANK_CODE = 4'hA;
    localparam logic [3:0] NIXIE_ERR_CODE   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_LATCH = 2'd2
    } nixie_state_e;

    // Decoded view of one complete frame, committed to the outputs as a unit.
    typedef struct packed {
        logic [NIXIE_BCD_W-1:0] bcd;
        logic [NIXIE_DP_W-1:0]  dp;
        logic [NIXIE_TUBES-1:0] derr;
    } nixie_frame_t;

endpackage

// File: rtl/nixie_digit_decode.sv
// One-hot tube digit field to BCD code (combinational).
//   onehot_i : field bits 1..10 of a tube; bit i set means digit (i+1) mod 10
//   code_o   : BCD digit, NIXIE_BLANK_CODE for an empty field, NIXIE_ERR_CODE for multi-hot
//   err_o    : high when two or more field bits are set
module nixie_digit_decode
    import nixie_pkg::*;
(
    input  logic [NIXIE_DIGIT_BITS-1:0] onehot_i,
    output logic [3:0]                  code_o,
    output logic                        err_o
);

    logic [3:0] ones_c;
    logic [3:0] digit_c;

    // Population count plus the digit of the (last) set bit.
    always_comb begin
        ones_c  = 4'd0;
        digit_c = NIXIE_BLANK_CODE;
        for (int unsigned i = 0; i < NIXIE_DIGIT_BITS; i++) begin
            if (onehot_i[i]) begin
                ones_c  = ones_c + 4'd1;
                digit_c = (i == NIXIE_DIGIT_BITS - 1) ? 4'd0 : 4'(i + 1);
            end
        end
    end

    assign err_o  = (ones_c > 4'd1);
    assign code_o = err_o ? NIXIE_ERR_CODE : digit_c;

endmodule

// File: rtl/nixie_frame_decoder.sv
// Receives 96-bit frames from a nixie driver bus (clock / latch-enable /
// data), checks the length and decodes eight one-hot tube fields.
//   clk, rst         : system clock, synchronous active-high reset
//   NIXIE_CLK/LE/DIN : asynchronous bus pins, synchronized internally
//   NixieBCD         : 8 BCD digits, tube 0 in [31:28]
//   digitpoint       : left points [15:8], right points [7:0], tube 0 at MSB
//   frame_valid      : one-cycle pulse when a 96-bit frame is committed
//   frame_err        : one-cycle pulse when a frame has the wrong length
//   digit_err        : multi-hot flags per tube, tube 0 at bit 7
//   frame_count      : number of committed frames, wrapping
module nixie_frame_decoder
    import nixie_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   NIXIE_CLK,
    input  logic                   NIXIE_LE,
    input  logic                   NIXIE_DIN,
    output logic [NIXIE_BCD_W-1:0] NixieBCD,
    output logic [NIXIE_DP_W-1:0]  digitpoint,
    output logic                   frame_valid,
    output logic                   frame_err,
    output logic [NIXIE_TUBES-1:0] digit_err,
    output logic [15:0]            frame_count
);

    localparam int unsigned CNT_W = NIXIE_CNT_W;

    // [0] = sync stage 1, [1] = sync stage 2, [2] = edge reference
    logic [2:0] nclk_q;
    logic [2:0] le_q;
    logic [1:0] din_q;

    logic clk_rise_c;
    logic le_rise_c;
    logic le_fall_c;
    logic din_s_c;

    nixie_state_e state_q, state_d;
    logic         fall_pend_q, fall_pend_d;

    logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [NIXIE_FRAME_BITS-1:0] shift_q, shift_d;

    logic clear_c;
    logic shift_c;
    logic commit_ok_c;
    logic commit_err_c;
    logic pend_set_c;

    logic [NIXIE_BCD_W-1:0] dec_bcd_c;
    logic [NIXIE_DP_W-1:0]  dec_dp_c;
    logic [NIXIE_TUBES-1:0] dec_err_c;
    nixie_frame_t           dec_c;

    // Input synchronizers; LE resets high and CLK/DIN low so reset release is edge-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            nclk_q <= 3'b000;
            le_q   <= 3'b111;
            din_q  <= 2'b00;
        end else begin
            nclk_q <= {nclk_q[1:0], NIXIE_CLK};
            le_q   <= {le_q[1:0], NIXIE_LE};
            din_q  <= {din_q[0], NIXIE_DIN};
        end
    end

    assign clk_rise_c = nclk_q[1] & ~nclk_q[2];
    assign le_rise_c  = le_q[1] & ~le_q[2];
    assign le_fall_c  = ~le_q[1] & le_q[2];
    assign din_s_c    = din_q[1];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (le_fall_c || fall_pend_q) state_d = ST_RECV;
            ST_RECV:  if (le_rise_c) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM control strobes. An LE fall seen during LATCH is remembered for one
    // cycle so the following IDLE cycle can still start the next frame.
    always_comb begin
        clear_c      = 1'b0;
        shift_c      = 1'b0;
        commit_ok_c  = 1'b0;
        commit_err_c = 1'b0;
        pend_set_c   = 1'b0;
        unique case (state_q)
            ST_IDLE:  clear_c = le_fall_c || fall_pend_q;
            ST_RECV:  shift_c = clk_rise_c;
            ST_LATCH: begin
                commit_ok_c  = (bit_cnt_q == CNT_W'(NIXIE_FRAME_BITS));
                commit_err_c = (bit_cnt_q != CNT_W'(NIXIE_FRAME_BITS));
                pend_set_c   = le_fall_c;
            end
            default: ;
        endcase
    end

    // Shift register and saturating bit counter next state.
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        fall_pend_d = pend_set_c;
        if (clear_c) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (shift_c) begin
            shift_d = {din_s_c, shift_q[NIXIE_FRAME_BITS-1:1]};
            if (bit_cnt_q != CNT_W'(NIXIE_FRAME_BITS + 1)) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            fall_pend_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            fall_pend_q <= fall_pend_d;
        end
    end

    // Per-tube field split: left point, ten one-hot digit bits, right point.
    for (genvar j = 0; j < NIXIE_TUBES; j++) begin : g_tube
        nixie_digit_decode u_digit (
            .onehot_i (shift_q[NIXIE_FIELD_BITS*j+1 +: NIXIE_DIGIT_BITS]),
            .code_o   (dec_bcd_c[4*(NIXIE_TUBES-1-j) +: 4]),
            .err_o    (dec_err_c[NIXIE_TUBES-1-j])
        );
        assign dec_dp_c[NIXIE_DP_W-1-j]  = shift_q[NIXIE_FIELD_BITS*j];
        assign dec_dp_c[NIXIE_TUBES-1-j] = shift_q[NIXIE_FIELD_BITS*j+NIXIE_FIELD_BITS-1];
    end

    assign dec_c = '{bcd: dec_bcd_c, dp: dec_dp_c, derr: dec_err_c};

    // Output registers: data and count change only on a good frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            NixieBCD    <= '0;
            digitpoint  <= '0;
            digit_err   <= '0;
            frame_count <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= commit_ok_c;
            frame_err   <= commit_err_c;
            if (commit_ok_c) begin
                NixieBCD    <= dec_c.bcd;
                digitpoint  <= dec_c.dp;
                digit_err   <= dec_c.derr;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nixie_frame_decoder.sv
// Self-checking bench for nixie_frame_decoder: drives bus frames bit by bit
// and compares the outputs with a frame-level reference model.
module tb_nixie_frame_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        NIXIE_CLK;
    logic        NIXIE_LE;
    logic        NIXIE_DIN;
    logic [31:0] NixieBCD;
    logic [15:0] digitpoint;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  digit_err;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int ecnt   = 0;

    logic [31:0] exp_bcd;
    logic [15:0] exp_dp;
    logic [7:0]  exp_derr;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    nixie_frame_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .NIXIE_CLK   (NIXIE_CLK),
        .NIXIE_LE    (NIXIE_LE),
        .NIXIE_DIN   (NIXIE_DIN),
        .NixieBCD    (NixieBCD),
        .digitpoint  (digitpoint),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .digit_err   (digit_err),
        .frame_count (frame_count)
    );

    // Pulse monitor: each high cycle counts once, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) vcnt++;
        if (frame_err === 1'b1) ecnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Build a frame from tube digits (A = blank) and point bits.
    function automatic logic [127:0] encode(input logic [31:0] bcd, input logic [15:0] dp);
        logic [127:0] d;
        int dig;
        d = '0;
        for (int j = 0; j < 8; j++) begin
            d[12*j]      = dp[15-j];
            d[12*j + 11] = dp[7-j];
            dig = int'(bcd[31-4*j -: 4]);
            if (dig <= 9) d[12*j + 1 + ((dig == 0) ? 9 : dig - 1)] = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [31:0] rand_bcd(input int max_digit);
        logic [31:0] b;
        for (int j = 0; j < 8; j++) b[4*j +: 4] = 4'($urandom_range(0, max_digit));
        return b;
    endfunction

    // Reference decode of a received frame.
    task automatic model_frame(input logic [127:0] d, input int n);
        logic [11:0] f;
        int ones, pos;
        if (n != 96) return;
        exp_derr = '0;
        for (int j = 0; j < 8; j++) begin
            f = d[12*j +: 12];
            exp_dp[15-j] = f[0];
            exp_dp[7-j]  = f[11];
            ones = 0;
            pos  = 0;
            for (int i = 0; i < 10; i++) if (f[1+i]) begin ones++; pos = i; end
            if (ones == 0) exp_bcd[31-4*j -: 4] = 4'hA;
            else if (ones == 1) exp_bcd[31-4*j -: 4] = 4'((pos + 1) % 10);
            else begin exp_bcd[31-4*j -: 4] = 4'hF; exp_derr[7-j] = 1'b1; end
        end
        exp_cnt = exp_cnt + 16'd1;
    endtask

    // Send n stream bits (bit 0 first); 2 clk cycles per bus level.
    task automatic send_bits(input logic [127:0] d, input int n, input bit same_edge, input bit raise_le);
        NIXIE_LE = 1'b0;
        wait_cyc(2);
        for (int k = 0; k < n; k++) begin
            NIXIE_DIN = d[k];
            wait_cyc(2);
            NIXIE_CLK = 1'b1;
            if (same_edge && k == n - 1) NIXIE_LE = 1'b1;
            wait_cyc(2);
            NIXIE_CLK = 1'b0;
        end
        if (raise_le && !same_edge) begin
            wait_cyc(1);
            NIXIE_LE = 1'b1;
        end
    endtask

    task automatic test_reset();
        NIXIE_CLK = 1'b0; NIXIE_LE = 1'b1; NIXIE_DIN = 1'b0; rst = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(3);
        exp_bcd = '0; exp_dp = '0; exp_derr = '0; exp_cnt = '0;
        checks++; if (NixieBCD !== 32'h0) begin errors++; $display("FAIL reset_bcd: got %h want 00000000", NixieBCD); end
        checks++; if (digitpoint !== 16'h0) begin errors++; $display("FAIL reset_dp: got %h want 0000", digitpoint); end
        checks++; if (digit_err !== 8'h0) begin errors++; $display("FAIL reset_derr: got %h want 00", digit_err); end
        checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0000", frame_count); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
    endtask

    task automatic test_good_frame();
        logic [127:0] d;
        int v0 = vcnt, e0 = ecnt;
        d = encode(32'h12345678, 16'h8001);
        send_bits(d, 96, 1'b0, 1'b1);
        wait_cyc(8);
        model_frame(d, 96);
        checks++; if (NixieBCD !== 32'h12345678) begin errors++; $display("FAIL good_bcd: got %h want 12345678", NixieBCD); end
        checks++; if (digitpoint !== 16'h8001) begin errors++; $display("FAIL good_dp: got %h want 8001", digitpoint); end
        checks++; if (digit_err !== 8'h00) begin errors++; $display("FAIL good_derr: got %h want 00", digit_err); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL good_count: got %h want 0001", frame_count); end
        checks++; if (vcnt - v0 != 1) begin errors++; $display("FAIL good_valid_pulses: got %0d want 1", vcnt - v0); end
        checks++; if (ecnt - e0 != 0) begin errors++; $display("FAIL good_err_pulses: got %0d want 0", ecnt - e0); end
    endtask

    task automatic test_wrong_length();
        int lens[3] = '{95, 97, 0};
        logic [127:0] d;
        foreach (lens[i]) begin
            int v0 = vcnt, e0 = ecnt;
            d = {$urandom, $urandom, $urandom, $urandom};
            send_bits(d, lens[i], 1'b0, 1'b1);
            wait_cyc(8);
            model_frame(d, lens[i]);
            checks++; if (ecnt - e0 != 1) begin errors++; $display("FAIL len%0d_err_pulses: got %0d want 1", lens[i], ecnt - e0); end
            checks++; if (vcnt - v0 != 0) begin errors++; $display("FAIL len%0d_valid_pulses: got %0d want 0", lens[i], vcnt - v0); end
            checks++; if (NixieBCD !== exp_bcd) begin errors++; $display("FAIL len%0d_bcd: got %h want %h", lens[i], NixieBCD, exp_bcd); end
            checks++; if (digitpoint !== exp_dp) begin errors++; $display("FAIL len%0d_dp: got %h want %h", lens[i], digitpoint, exp_dp); end
            checks++; if (frame_count !== exp_cnt) begin errors++; $display("FAIL len%0d_count: got %h want %h", lens[i], frame_count, exp_cnt); end
        end
    endtask

    task automatic test_field_bits();
        logic [127:0] d;
        int v0 = vcnt;
        d = encode(rand_bcd(9), 16'($urandom));
        d[1 +: 10] = '0;
        d[2] = 1'b1;
        d[3] = 1'b1;
        d[85 +: 10] = '0;
        send_bits(d, 96, 1'b0, 1'b1);
        wait_cyc(8);
        model_frame(d, 96);
        checks++; if (NixieBCD[31:28] !== 4'hF) begin errors++; $display("FAIL field_tube0: got %h want f", NixieBCD[31:28]); end
        checks++; if (NixieBCD[3:0] !== 4'hA) begin errors++; $display("FAIL field_tube7: got %h want a", NixieBCD[3:0]); end
        checks++; if (digit_err !== 8'h80) begin errors++; $display("FAIL field_derr: got %h want 80", digit_err); end
        checks++; if (NixieBCD !== exp_bcd) begin errors++; $display("FAIL field_bcd: got %h want %h", NixieBCD, exp_bcd); end
        checks++; if (vcnt - v0 != 1) begin errors++; $display("FAIL field_valid_pulses: got %0d want 1", vcnt - v0); end
    endtask

    task automatic test_random_frames();
        logic [127:0] d;
        for (int it = 0; it < 6; it++) begin
            int v0 = vcnt;
            d = encode(rand_bcd(10), 16'($urandom));
            for (int j = 0; j < 8; j++) if ($urandom_range(0, 3) == 0) d[12*j + 1 +: 10] = 10'($urandom);
            send_bits(d, 96, 1'b0, 1'b1);
            wait_cyc(8);
            model_frame(d, 96);
            checks++; if (NixieBCD !== exp_bcd) begin errors++; $display("FAIL rand%0d_bcd: got %h want %h", it, NixieBCD, exp_bcd); end
            checks++; if (digitpoint !== exp_dp) begin errors++; $display("FAIL rand%0d_dp: got %h want %h", it, digitpoint, exp_dp); end
            checks++; if (digit_err !== exp_derr) begin errors++; $display("FAIL rand%0d_derr: got %h want %h", it, digit_err, exp_derr); end
            checks++; if (frame_count !== exp_cnt) begin errors++; $display("FAIL rand%0d_count: got %h want %h", it, frame_count, exp_cnt); end
            checks++; if (vcnt - v0 != 1) begin errors++; $display("FAIL rand%0d_valid_pulses: got %0d want 1", it, vcnt - v0); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] d;
        int v0, e0;
        v0 = vcnt; e0 = ecnt;
        d = {$urandom, $urandom, $urandom, $urandom};
        send_bits(d, 40, 1'b0, 1'b0);
        rst = 1'b1;
        NIXIE_LE = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(8);
        exp_bcd = '0; exp_dp = '0; exp_derr = '0; exp_cnt = '0;
        checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL midrst_count0: got %h want 0000", frame_count); end
        checks++; if (vcnt - v0 != 0 || ecnt - e0 != 0) begin errors++; $display("FAIL midrst_pulses: got %0d/%0d want 0/0", vcnt - v0, ecnt - e0); end
        d = encode(32'h00000000, 16'h0000);
        send_bits(d, 96, 1'b0, 1'b1);
        wait_cyc(8);
        model_frame(d, 96);
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL midrst_count1: got %h want 0001", frame_count); end
        checks++; if (NixieBCD !== 32'h00000000) begin errors++; $display("FAIL midrst_bcd: got %h want 00000000", NixieBCD); end
        checks++; if (digitpoint !== exp_dp) begin errors++; $display("FAIL midrst_dp: got %h want %h", digitpoint, exp_dp); end
        checks++; if (vcnt - v0 != 1) begin errors++; $display("FAIL midrst_valid_pulses: got %0d want 1", vcnt - v0); end
    endtask

    task automatic test_edge_timing();
        logic [127:0] d;
        int v0 = vcnt, e0 = ecnt;
        d = encode(rand_bcd(9), 16'($urandom));
        send_bits(d, 96, 1'b1, 1'b1);
        wait_cyc(8);
        model_frame(d, 96);
        checks++; if (vcnt - v0 != 1 || ecnt - e0 != 0) begin errors++; $display("FAIL edge_same_pulses: got %0d/%0d want 1/0", vcnt - v0, ecnt - e0); end
        checks++; if (NixieBCD !== exp_bcd) begin errors++; $display("FAIL edge_same_bcd: got %h want %h", NixieBCD, exp_bcd); end
        checks++; if (digitpoint !== exp_dp) begin errors++; $display("FAIL edge_same_dp: got %h want %h", digitpoint, exp_dp); end
        v0 = vcnt; e0 = ecnt;
        for (int k = 0; k < 5; k++) begin
            NIXIE_DIN = 1'($urandom);
            NIXIE_CLK = 1'b1; wait_cyc(2);
            NIXIE_CLK = 1'b0; wait_cyc(2);
        end
        wait_cyc(6);
        checks++; if (vcnt - v0 != 0 || ecnt - e0 != 0) begin errors++; $display("FAIL edge_idle_pulses: got %0d/%0d want 0/0", vcnt - v0, ecnt - e0); end
        checks++; if (frame_count !== exp_cnt) begin errors++; $display("FAIL edge_idle_count: got %h want %h", frame_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] da, db;
        int v0 = vcnt, e0 = ecnt;
        da = encode(rand_bcd(9), 16'($urandom));
        db = encode(rand_bcd(9), 16'($urandom));
        send_bits(da, 96, 1'b0, 1'b1);
        wait_cyc(1);
        send_bits(db, 96, 1'b0, 1'b1);
        wait_cyc(8);
        model_frame(da, 96);
        model_frame(db, 96);
        checks++; if (vcnt - v0 != 2 || ecnt - e0 != 0) begin errors++; $display("FAIL b2b_pulses: got %0d/%0d want 2/0", vcnt - v0, ecnt - e0); end
        checks++; if (NixieBCD !== exp_bcd) begin errors++; $display("FAIL b2b_bcd: got %h want %h", NixieBCD, exp_bcd); end
        checks++; if (digitpoint !== exp_dp) begin errors++; $display("FAIL b2b_dp: got %h want %h", digitpoint, exp_dp); end
        checks++; if (frame_count !== exp_cnt) begin errors++; $display("FAIL b2b_count: got %h want %h", frame_count, exp_cnt); end
    endtask

    task automatic test_wrap();
        logic [127:0] d;
        int v0;
        force dut.frame_count = 16'hFFFF;
        wait_cyc(1);
        release dut.frame_count;
        wait_cyc(1);
        exp_cnt = 16'hFFFF;
        checks++; if (frame_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffff", frame_count); end
        v0 = vcnt;
        d = encode(rand_bcd(9), 16'($urandom));
        send_bits(d, 96, 1'b0, 1'b1);
        wait_cyc(8);
        model_frame(d, 96);
        checks++; if (frame_count !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h want 0000", frame_count); end
        checks++; if (vcnt - v0 != 1) begin errors++; $display("FAIL wrap_valid_pulses: got %0d want 1", vcnt - v0); end
        checks++; if (NixieBCD !== exp_bcd) begin errors++; $display("FAIL wrap_bcd: got %h want %h", NixieBCD, exp_bcd); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_wrong_length();
        test_field_bits();
        test_random_frames();
        test_reset_mid_frame();
        test_edge_timing();
        test_back_to_back();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
